branch_predictor: RTL and testbench

- Fetch-stage next-PC predictor for the Y86-64 pipeline; a parametrised successor to the static call/jump predictor.
- Adds a pattern history table (PHT) of 2-bit saturating counters for conditional jumps and a return address stack (RAS) for `ret`.
- Trained by the execute stage with resolved conditional-jump outcomes.
- Drives f_predPC into the F-register predPC path.

---
 rtl/y86_pkg.sv | 33 +++
 rtl/return_stack.sv | 54 +++++
 rtl/branch_predictor.sv | 102 ++++++++++
 tb/tb_branch_predictor.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the 2-bit branch counter helper used by the fetch predictor.
package y86_pkg;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned ICODE_W = 4;

    localparam logic [ICODE_W-1:0] IJXX       = 4'h7;
    localparam logic [ICODE_W-1:0] ICALL      = 4'h8;
    localparam logic [ICODE_W-1:0] IRET       = 4'h9;
    localparam logic [ICODE_W-1:0] FUN_UNCOND = 4'h0;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    // Saturating step of a 2-bit counter toward the resolved outcome.
    function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
        ctr_e n;
        n = c;
        case (c)
            SNT:     n = taken ? WNT : SNT;
            WNT:     n = taken ? WT  : SNT;
            WT:      n = taken ? ST  : WNT;
            ST:      n = taken ? ST  : WT;
            default: n = c;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return address stack with saturating occupancy and an empty-pop guard.
module return_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [W-1:0]            push_data,
    output logic [W-1:0]            top,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_ptr_inc;
    logic             w_pop_ok;
    logic             w_full;

    assign w_ptr_inc = r_ptr + PTR_W'(1);
    assign w_pop_ok  = pop && !push && (r_count != '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));

    // r_ptr addresses the current top; a push when full wraps onto the oldest entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (push) begin
            r_ptr <= w_ptr_inc;
            if (!w_full) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (w_pop_ok) begin
            r_ptr   <= r_ptr - PTR_W'(1);
            r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[w_ptr_inc] <= push_data;
        end
    end

    assign top   = r_mem[r_ptr];
    assign count = r_count;

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage next-PC predictor: call/jmp to valC, PHT-steered conditional jumps, RAS for ret.
module branch_predictor
    import y86_pkg::*;
#(
    parameter int unsigned PHT_ENTRIES = 16,
    parameter int unsigned RAS_DEPTH   = 8,
    parameter int unsigned PRED_MODE   = 1,
    parameter logic [1:0]  CTR_INIT    = 2'b01
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         f_valid,
    input  logic                         f_stall,
    input  logic [63:0]                  f_pc,
    input  logic [3:0]                   f_icode,
    input  logic [3:0]                   f_ifun,
    input  logic [63:0]                  f_valC,
    input  logic [63:0]                  f_valP,
    output logic [63:0]                  f_predPC,
    output logic                         f_pred_taken,
    input  logic                         e_upd_valid,
    input  logic [63:0]                  e_upd_pc,
    input  logic                         e_upd_taken,
    output logic [$clog2(RAS_DEPTH):0]   ras_count
);

    localparam int unsigned IDX_W = $clog2(PHT_ENTRIES);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

    ctr_e              r_pht [PHT_ENTRIES];
    logic [IDX_W-1:0]  w_rd_idx;
    logic [IDX_W-1:0]  w_upd_idx;
    ctr_e              w_rd_ctr;
    logic              w_ras_push;
    logic              w_ras_pop;
    logic [63:0]       w_ras_top;
    logic [CNT_W-1:0]  w_ras_count;
    logic              w_unused_hi;

    assign w_rd_idx    = f_pc[IDX_W-1:0];
    assign w_upd_idx   = e_upd_pc[IDX_W-1:0];
    assign w_rd_ctr    = r_pht[w_rd_idx];
    assign w_unused_hi = ^{f_pc[63:IDX_W], e_upd_pc[63:IDX_W]};

    // Training from execute; a same-cycle lookup reads the old counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(PHT_ENTRIES); i++) begin
                r_pht[i] <= ctr_e'(CTR_INIT);
            end
        end else if (e_upd_valid) begin
            r_pht[w_upd_idx] <= ctr_next(r_pht[w_upd_idx], e_upd_taken);
        end
    end

    assign w_ras_push = f_valid && !f_stall && (f_icode == ICALL);
    assign w_ras_pop  = f_valid && !f_stall && (f_icode == IRET);

    return_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_ras_push),
        .pop       (w_ras_pop),
        .push_data (f_valP),
        .top       (w_ras_top),
        .count     (w_ras_count)
    );

    // Same-cycle prediction, independent of f_valid.
    always_comb begin
        f_predPC     = f_valP;
        f_pred_taken = 1'b0;
        case (f_icode)
            ICALL: begin
                f_predPC     = f_valC;
                f_pred_taken = 1'b1;
            end
            IJXX: begin
                if ((f_ifun == FUN_UNCOND) || (PRED_MODE == 0) || w_rd_ctr[1]) begin
                    f_predPC     = f_valC;
                    f_pred_taken = 1'b1;
                end
            end
            IRET: begin
                if (w_ras_count != '0) begin
                    f_predPC     = w_ras_top;
                    f_pred_taken = 1'b1;
                end
            end
            default: begin
                f_predPC     = f_valP;
                f_pred_taken = 1'b0;
            end
        endcase
    end

    assign ras_count = w_ras_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: dynamic and static instances share stimulus, checked against a queue/array model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_valid, f_stall, e_upd_valid, e_upd_taken;
    logic [63:0] f_pc, f_valC, f_valP, e_upd_pc;
    logic [3:0]  f_icode, f_ifun;

    logic [63:0] pc_dyn, pc_sta;
    logic        tk_dyn, tk_sta;
    logic [3:0]  cnt_dyn, cnt_sta;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] m_ras[$];
    int          m_pht[16];

    always #5 clk = ~clk;

    branch_predictor #(.PHT_ENTRIES(16), .RAS_DEPTH(8), .PRED_MODE(1), .CTR_INIT(2'b01)) dut_dyn (
        .clk(clk), .rst_n(rst_n), .f_valid(f_valid), .f_stall(f_stall), .f_pc(f_pc),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_valC(f_valC), .f_valP(f_valP),
        .f_predPC(pc_dyn), .f_pred_taken(tk_dyn), .e_upd_valid(e_upd_valid),
        .e_upd_pc(e_upd_pc), .e_upd_taken(e_upd_taken), .ras_count(cnt_dyn));

    branch_predictor #(.PHT_ENTRIES(16), .RAS_DEPTH(8), .PRED_MODE(0), .CTR_INIT(2'b01)) dut_sta (
        .clk(clk), .rst_n(rst_n), .f_valid(f_valid), .f_stall(f_stall), .f_pc(f_pc),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_valC(f_valC), .f_valP(f_valP),
        .f_predPC(pc_sta), .f_pred_taken(tk_sta), .e_upd_valid(e_upd_valid),
        .e_upd_pc(e_upd_pc), .e_upd_taken(e_upd_taken), .ras_count(cnt_sta));

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    // Model: counters as ints with clamping, RAS as a bounded queue (oldest dropped at the front).
    task automatic model_reset();
        m_ras.delete();
        for (int i = 0; i < 16; i++) m_pht[i] = 1;
    endtask

    function automatic logic [64:0] model_pred(input int mode);
        logic [64:0] r;
        r = {1'b0, f_valP};
        if (f_icode == 4'h8) r = {1'b1, f_valC};
        else if (f_icode == 4'h7) begin
            if (f_ifun == 4'h0 || mode == 0 || m_pht[int'(f_pc % 16)] >= 2) r = {1'b1, f_valC};
        end else if (f_icode == 4'h9 && m_ras.size() > 0) r = {1'b1, m_ras[$]};
        return r;
    endfunction

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (rst_n) begin
            if (e_upd_valid) begin
                int k;
                k = int'(e_upd_pc % 16);
                if (e_upd_taken) m_pht[k] = (m_pht[k] < 3) ? m_pht[k] + 1 : 3;
                else             m_pht[k] = (m_pht[k] > 0) ? m_pht[k] - 1 : 0;
            end
            if (f_valid && !f_stall) begin
                if (f_icode == 4'h8) begin
                    m_ras.push_back(f_valP);
                    if (m_ras.size() > 8) void'(m_ras.pop_front());
                end else if (f_icode == 4'h9 && m_ras.size() > 0) begin
                    void'(m_ras.pop_back());
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic [64:0] e0, e1;
        e0 = model_pred(0);
        e1 = model_pred(1);
        check("dyn_predPC", pc_dyn, e1[63:0]);
        check("dyn_taken", 64'(tk_dyn), 64'(e1[64]));
        check("sta_predPC", pc_sta, e0[63:0]);
        check("sta_taken", 64'(tk_sta), 64'(e0[64]));
        check("dyn_count", 64'(cnt_dyn), 64'(m_ras.size()));
        check("sta_count", 64'(cnt_sta), 64'(m_ras.size()));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic fetch(input logic v, input logic st, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] pc, input logic [63:0] vc, input logic [63:0] vp);
        f_valid = v; f_stall = st; f_icode = ic; f_ifun = fn; f_pc = pc; f_valC = vc; f_valP = vp;
    endtask

    task automatic upd(input logic v, input logic [63:0] pc, input logic tk);
        e_upd_valid = v; e_upd_pc = pc; e_upd_taken = tk;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        upd(1'b0, 64'h0, 1'b0);
        fetch(1'b1, 1'b0, 4'h9, 4'h0, 64'h0, 64'h0, 64'h40);
        #3;
        check("reset_count", 64'(cnt_dyn), 64'd0);
        check("reset_ret_valP", pc_dyn, 64'h40);
        tick();
        rst_n = 1'b1;

        // Call then ret
        fetch(1'b1, 1'b0, 4'h8, 4'h0, 64'h100, 64'h200, 64'h109);
        #1 check("call_predPC", pc_dyn, 64'h200);
        tick();
        fetch(1'b1, 1'b0, 4'h9, 4'h0, 64'h109, 64'h0, 64'h10a);
        #1 check("call_count", 64'(cnt_dyn), 64'd1);
        check("ret_predPC", pc_dyn, 64'h109);
        tick();
        fetch(1'b1, 1'b0, 4'h1, 4'h0, 64'h10a, 64'h0, 64'h10b);
        #1 check("ret_count", 64'(cnt_dyn), 64'd0);

        // Empty ret, then overflow by 9 calls and unwind 8 rets
        fetch(1'b1, 1'b0, 4'h9, 4'h0, 64'h3f, 64'h0, 64'h40);
        #1 check("empty_ret_pc", pc_dyn, 64'h40);
        check("empty_ret_tk", 64'(tk_dyn), 64'd0);
        tick();
        #1 check("empty_ret_count", 64'(cnt_dyn), 64'd0);
        for (int k = 1; k <= 9; k++) begin
            fetch(1'b1, 1'b0, 4'h8, 4'h0, 64'h500, 64'h600, 64'h1000 + 64'(k));
            tick();
        end
        fetch(1'b1, 1'b0, 4'h1, 4'h0, 64'h0, 64'h0, 64'h2);
        #1 check("full_count", 64'(cnt_dyn), 64'd8);
        for (int k = 9; k >= 2; k--) begin
            fetch(1'b1, 1'b0, 4'h9, 4'h0, 64'h0, 64'h0, 64'h5);
            #1 check("lifo_pop", pc_dyn, 64'h1000 + 64'(k));
            tick();
        end
        #1 check("drained_count", 64'(cnt_dyn), 64'd0);
        check("drained_ret", pc_dyn, 64'h5);

        // Conditional jump training at 0x30
        fetch(1'b1, 1'b0, 4'h7, 4'h1, 64'h30, 64'h80, 64'h39);
        #1 check("jle_init_dyn", pc_dyn, 64'h39);
        check("jle_init_sta", pc_sta, 64'h80);
        upd(1'b1, 64'h30, 1'b1);
        tick();
        upd(1'b0, 64'h30, 1'b0);
        #1 check("jle_after1", pc_dyn, 64'h80);
        upd(1'b1, 64'h30, 1'b1);
        repeat (3) tick();
        upd(1'b1, 64'h30, 1'b0);
        tick();
        upd(1'b0, 64'h0, 1'b0);
        #1 check("jle_ctr2", pc_dyn, 64'h80);

        // Same-cycle lookup/update: old value visible, new value next cycle
        fetch(1'b1, 1'b0, 4'h7, 4'h2, 64'h45, 64'h90, 64'h4e);
        upd(1'b1, 64'h45, 1'b1);
        #1 check("bypass_old", pc_dyn, 64'h4e);
        tick();
        upd(1'b0, 64'h0, 1'b0);
        #1 check("bypass_new", pc_dyn, 64'h90);

        // Stall and invalid fetch suppress RAS updates
        fetch(1'b1, 1'b0, 4'h8, 4'h0, 64'h700, 64'h800, 64'h777);
        tick();
        fetch(1'b1, 1'b1, 4'h8, 4'h0, 64'h700, 64'h800, 64'h888);
        repeat (3) tick();
        #1 check("stall_count", 64'(cnt_dyn), 64'd1);
        fetch(1'b0, 1'b0, 4'h8, 4'h0, 64'h700, 64'h800, 64'h999);
        repeat (3) tick();
        #1 check("invalid_count", 64'(cnt_dyn), 64'd1);
        fetch(1'b1, 1'b1, 4'h9, 4'h0, 64'h0, 64'h0, 64'h1);
        #1 check("stall_ret_top", pc_dyn, 64'h777);
        tick();
        #1 check("stall_ret_count", 64'(cnt_dyn), 64'd1);

        // Static mode with counter 0, then asynchronous reset mid-cycle
        rst_n = 1'b0;
        #1 check("rst_count", 64'(cnt_dyn), 64'd0);
        tick();
        rst_n = 1'b1;
        fetch(1'b1, 1'b0, 4'h1, 4'h0, 64'h0, 64'h0, 64'h2);
        upd(1'b1, 64'h30, 1'b0);
        tick();
        upd(1'b0, 64'h0, 1'b0);
        fetch(1'b1, 1'b0, 4'h7, 4'h1, 64'h30, 64'h80, 64'h39);
        #1 check("static_ctr0", pc_sta, 64'h80);
        check("dyn_ctr0", pc_dyn, 64'h39);
        fetch(1'b1, 1'b0, 4'h8, 4'h0, 64'h50, 64'h60, 64'habc);
        upd(1'b1, 64'h30, 1'b1);
        repeat (3) tick();
        upd(1'b0, 64'h0, 1'b0);
        fetch(1'b1, 1'b0, 4'h7, 4'h1, 64'h30, 64'h80, 64'h39);
        #1 check("pre_rst_count", 64'(cnt_dyn), 64'd3);
        check("pre_rst_pred", pc_dyn, 64'h80);
        rst_n = 1'b0;
        #1 check("async_rst_pht", pc_dyn, 64'h39);
        check("async_rst_cnt_dyn", 64'(cnt_dyn), 64'd0);
        check("async_rst_cnt_sta", 64'(cnt_sta), 64'd0);
        fetch(1'b1, 1'b0, 4'h9, 4'h0, 64'h0, 64'h0, 64'h44);
        #1 check("async_rst_ret", pc_dyn, 64'h44);
        tick();
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
